// File: rtl/uart_pkg.sv
// Shared constants and state type for the UART TX write-port arbiter.
package uart_pkg;

  // Arbiter FSM states; encoding fixed so IDLE is the all-zero reset value.
  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  // Default channel count and per-grant byte limit.
  localparam int unsigned NUM_REQ_DEF   = 4;
  localparam int unsigned MAX_BURST_DEF = 16;

  // Channel index and burst counter widths (up to 8 channels, 255-byte bursts).
  localparam int unsigned ID_W  = 3;
  localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Rotating-priority selector: finds the first valid channel after last_id,
// wrapping around, so the most recently served channel is considered last.
module rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    last_id,
  output logic               found,
  output logic [ID_W-1:0]    next_id
);

  // Scan candidates last_id+1 .. last_id+NUM_REQ (mod NUM_REQ); first hit wins.
  always_comb begin
    int unsigned idx;
    found   = 1'b0;
    next_id = '0;
    idx     = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = 32'(last_id) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!found && (j == idx) && req_valid[j]) begin
          found   = 1'b1;
          next_id = ID_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART TX FIFO write port among byte-stream
// requesters. A grant is held for a whole packet or until MAX_BURST bytes,
// so packets from different channels never interleave in the FIFO.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ   = NUM_REQ_DEF,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 uart_running,
  input  logic                 tx_fifo_full,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 uart_write,
  output logic [7:0]           data_write,
  output logic                 grant_valid,
  output logic [ID_W-1:0]      grant_id,
  output logic [CNT_W-1:0]     burst_cnt
);

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic [ID_W-1:0]   last_id;
  logic [ID_W-1:0]   last_id_nxt;
  logic [ID_W-1:0]   grant_id_nxt;
  logic              grant_valid_nxt;
  logic [CNT_W-1:0]  burst_cnt_nxt;

  logic              pick_found;
  logic [ID_W-1:0]   pick_id;

  logic              sel_valid;
  logic              sel_last;
  logic [7:0]        sel_data;
  logic              tx_ok;
  logic              fire;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req_valid (req_valid),
    .last_id   (last_id),
    .found     (pick_found),
    .next_id   (pick_id)
  );

  // Route the granted channel's valid/last/data onto the shared select lines.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[8*i +: 8];
      end
    end
  end

  // Next-state and handshake logic: arbitrate in IDLE, stream bytes in XFER.
  always_comb begin
    state_nxt       = state;
    last_id_nxt     = last_id;
    grant_id_nxt    = grant_id;
    grant_valid_nxt = grant_valid;
    burst_cnt_nxt   = burst_cnt;
    req_ready       = '0;
    uart_write      = 1'b0;
    data_write      = '0;
    tx_ok           = uart_running & ~tx_fifo_full;
    fire            = 1'b0;

    unique case (state)
      IDLE: begin
        if (uart_running && pick_found) begin
          state_nxt       = XFER;
          grant_valid_nxt = 1'b1;
          grant_id_nxt    = pick_id;
          burst_cnt_nxt   = '0;
        end
      end

      XFER: begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          if (grant_id == ID_W'(i)) begin
            req_ready[i] = tx_ok;
          end
        end
        fire = sel_valid & tx_ok;

        if (!uart_running) begin
          // UART stopped: abandon the partial packet, keep rotation point.
          state_nxt       = IDLE;
          grant_valid_nxt = 1'b0;
          grant_id_nxt    = '0;
        end else if (fire) begin
          uart_write    = 1'b1;
          data_write    = sel_data;
          burst_cnt_nxt = burst_cnt + CNT_W'(1);
          if (sel_last || (burst_cnt == CNT_W'(MAX_BURST - 1))) begin
            state_nxt       = IDLE;
            last_id_nxt     = grant_id;
            grant_valid_nxt = 1'b0;
            grant_id_nxt    = '0;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and grant registers; channel 0 has first priority after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      burst_cnt   <= '0;
      last_id     <= ID_W'(NUM_REQ - 1);
    end else begin
      state       <= state_nxt;
      grant_valid <= grant_valid_nxt;
      grant_id    <= grant_id_nxt;
      burst_cnt   <= burst_cnt_nxt;
      last_id     <= last_id_nxt;
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares the single UART TX FIFO write port among several byte-stream requesters. It sits between the requester channels and the UART interface unit's `uart_write` / `data_write_in` inputs, and holds a grant for a whole packet (or a bounded burst) so packets from different channels do not interleave. Flow control uses the TX FIFO full flag and the UART running flag exported in `uart_status`.

## Interface
- `NUM_REQ`, 4: number of requester channels (2..8).
- `MAX_BURST`, 16: maximum bytes accepted per grant before forced release (1..255).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `uart_running`  in  1  UART interface unit is in RUNNING (`uart_status[0]`).
- `tx_fifo_full`  in  1  TX FIFO full (`uart_status[7]`); valid for the current cycle.
- `req_valid`  in  NUM_REQ  per-channel byte valid.
- `req_data`  in  8*NUM_REQ  per-channel byte; channel i occupies bits [8i+7:8i].
- `req_last`  in  NUM_REQ  byte is the final byte of its packet.
- `req_ready`  out  NUM_REQ  per-channel accept; a byte transfers when valid & ready.
- `uart_write`  out  1  one-cycle write strobe to the UART interface TX write port.
- `data_write`  out  8  byte for the TX FIFO, valid while `uart_write` = 1.
- `grant_valid`  out  1  a channel currently holds the grant.
- `grant_id`  out  3  index of the granted channel (0 when none).
- `burst_cnt`  out  8  bytes accepted in the current grant.

## Operation
- States: IDLE, XFER.
- IDLE: if `uart_running` and any `req_valid`, select the first valid channel searching upward from `last_id+1` (wrapping); register `grant_id`, set `grant_valid`, clear `burst_cnt`, go to XFER. No transfer occurs in IDLE.
- XFER: fire = `req_valid[grant_id]` & ~`tx_fifo_full` & `uart_running`. `req_ready[grant_id]` = ~`tx_fifo_full` & `uart_running`; all other `req_ready` bits are 0. On fire: `uart_write` = 1, `data_write` = granted byte, `burst_cnt` += 1.
- Release (XFER -> IDLE, `last_id` <= `grant_id`, `grant_valid` <= 0): fire with `req_last` = 1, or fire with `burst_cnt` = MAX_BURST-1.
- Granted channel deasserting `req_valid` mid-packet: the grant is held and no bytes are written; there is no timeout.
- `uart_running` falling in XFER: next state IDLE, grant dropped, `last_id` unchanged, and the partial packet is abandoned by the arbiter. Channels resend.
- `tx_fifo_full` stalls without releasing the grant.
- `uart_write`, `data_write` and `req_ready` are combinational from registered state plus current inputs. Nothing is written when no channel fires, and `data_write` = 0 in that case.
- `burst_cnt` is 8 bits and saturates at MAX_BURST by construction; it never wraps.

## Timing
- Reset values: state IDLE, `grant_valid` 0, `grant_id` 0, `burst_cnt` 0, `last_id` NUM_REQ-1 (channel 0 gets first priority), `req_ready` 0, `uart_write` 0, `data_write` 0.
- Latency: `req_valid` seen in IDLE at cycle N -> grant at N+1 -> first byte written at N+1 if the FIFO is not full.
- Throughput: 1 byte/cycle within a grant. There is one idle arbitration cycle between grants.
- Simultaneous requests: strict rotation. A channel that just released its grant has lowest priority at the next arbitration.
- Reset asserted mid-packet: all state returns to reset values at the next edge, and the next grant goes to channel 0.

## Structure
- Shared package `uart_pkg`: state encoding constants (IDLE=0, XFER=1) and the default NUM_REQ/MAX_BURST constants.
- Sub-module `rr_pick`: combinational rotating-priority selector. Inputs are `req_valid` and `last_id`. Outputs are `found` and `next_id`. It is instantiated once.
- Top level holds the FSM, grant/`last_id` registers, burst counter, and the data mux.

## Test plan
- Single channel: ch1 sends 3 bytes 0x41,0x42,0x43 (last on 0x43) -> grant at N+1, `uart_write` on 3 consecutive cycles with those bytes, `grant_valid` drops after the third byte.
- All 4 channels request continuously, 1-byte packets -> grant order 0,1,2,3,0,… with one idle cycle between writes.
- Burst limit: MAX_BURST=4, ch2 sends a 10-byte packet while ch3 is waiting -> ch2 gets 4 bytes, ch3 gets a grant, then ch2 resumes.
- FIFO full: `tx_fifo_full` held for 5 cycles mid-packet -> `req_ready`=0 and no `uart_write` for 5 cycles, grant kept, and the packet completes after the stall.
- `uart_running` drops after 2 of 5 bytes -> grant released next cycle, no further writes, and arbitration restarts at `last_id`+1 when running returns.
- Synchronous `reset` during XFER on ch3 -> all outputs reach their reset values at the next edge, and ch0 is granted first afterwards.
